sseg_scan: RTL

SSEG_SCAN -- requirements
Module: sseg_scan

---
 rtl/sseg_scan.sv | 86 ++++++++
 1 files changed

// File: rtl/sseg_scan.sv
// Multiplexed 4-digit seven-segment anode scanner with per-digit enable mask.
// Define SSEG_SCAN_BLANK_EN to blank the anodes at the end of each digit period.
module sseg_scan #(
    parameter int PRESCALE     = 65536,
    parameter int BLANK_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       tick
);

    localparam int CW = $clog2(PRESCALE);

    if (PRESCALE < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE) begin : g_bad_param
        $error("sseg_scan: illegal PRESCALE/BLANK_CYCLES");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic          wrap;
    logic          blank;
    logic [1:0]    nxt_idx;
    logic [1:0]    cand;

`ifdef SSEG_SCAN_BLANK_EN
    assign blank = (cnt_q >= CW'(PRESCALE - BLANK_CYCLES));
`else
    assign blank = 1'b0;
`endif

    assign wrap = (cnt_q == CW'(PRESCALE - 1));

    // Scan downwards so the nearest enabled successor wins; an empty mask holds.
    always_comb begin
        nxt_idx = idx_q;
        cand    = idx_q;
        for (int k = 4; k >= 1; k--) begin
            cand = idx_q + 2'(k);
            if (digit_mask[cand]) begin
                nxt_idx = cand;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        an_d   = an_q;
        tick_d = 1'b0;
        if (en) begin
            cnt_d  = wrap ? '0 : cnt_q + CW'(1);
            idx_d  = wrap ? nxt_idx : idx_q;
            tick_d = wrap;
            if (digit_mask[idx_q] && !blank) begin
                an_d = ~(4'b0001 << idx_q);
            end else begin
                an_d = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign an        = an_q;
    assign digit_idx = idx_q;
    assign tick      = tick_q;

endmodule
